// File: rtl/fp_pkg.sv
// Shared types and constants for the single/word conversion unit.
package fp_pkg;

  typedef enum logic [1:0] {
    OP_CVT_S_W   = 2'b00,
    OP_TRUNC_W_S = 2'b01,
    OP_ROUND_W_S = 2'b10,
    OP_RESERVED  = 2'b11
  } fp_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int          EXP_BIAS     = 127;
  localparam logic [7:0]  EXP_WORD_MAX = 8'd158;
  localparam logic [31:0] FP_NEG_2_31  = 32'hCF000000;

endpackage

// File: rtl/fp_convert_unit_if.sv
// Request/result bundle between the FPU issue logic and the converter.
// Handshake: the master raises start with opcode/operand while busy=0; the
// unit captures them on that edge and raises busy. Starts seen while busy=1
// are dropped. Completion is a single-cycle done pulse; result and flags are
// valid from that pulse and stay stable until the next accepted start.
interface fp_convert_unit_if;
  import fp_pkg::*;

  logic        start;
  logic [1:0]  opcode;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        Inexact;
  logic        Overflow;
  logic        Invalid;
  conv_state_t state_dbg;

  modport master (
    output start, opcode, operand,
    input  busy, done, result, zero, Inexact, Overflow, Invalid, state_dbg
  );

  modport slave (
    input  start, opcode, operand,
    output busy, done, result, zero, Inexact, Overflow, Invalid, state_dbg
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-increment decision shared by int->float and float->int paths.
// mode=1 selects round-to-nearest-even, mode=0 truncates toward zero.
module fp_round_rne (
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  input  logic mode,
  output logic increment
);

  // Ties go up only when the kept value is odd.
  always_comb begin
    increment = mode & guard & (sticky | lsb);
  end

endmodule

// File: rtl/fp_convert_unit.sv
// Multi-cycle IEEE-754 single <-> word converter (cvt.s.w, trunc.w.s,
// round.w.s). Normalisation / alignment moves one bit per cycle.
module fp_convert_unit
  import fp_pkg::*;
#(
  parameter logic [31:0] INVALID_RESULT = 32'h7FFFFFFF
) (
  input logic              clk,
  input logic              reset,
  fp_convert_unit_if.slave bus
);

  conv_state_t state;
  fp_op_t      op;
  logic        sign;
  logic [31:0] work;      // int magnitude (cvt) or aligned significand (word)
  logic [7:0]  exp;
  logic [5:0]  cnt;       // remaining right shifts for float->int
  logic        guard_r;
  logic        sticky_r;
  logic        done_r;
  logic [31:0] result_r;
  logic        zero_r;
  logic        inexact_r;
  logic        overflow_r;
  logic        invalid_r;

  // Input field views used at capture time.
  logic [7:0]  in_e;
  logic [22:0] in_m;
  logic [31:0] abs_in;

  assign in_e   = bus.operand[30:23];
  assign in_m   = bus.operand[22:0];
  assign abs_in = bus.operand[31] ? (~bus.operand + 32'd1) : bus.operand;

  // Special-case classification: these finish straight from IDLE.
  logic        special;
  logic [31:0] sp_result;
  logic        sp_inexact;
  logic        sp_overflow;
  logic        sp_invalid;

  // Decode operands that need no shifting.
  always_comb begin
    special     = 1'b0;
    sp_result   = 32'd0;
    sp_inexact  = 1'b0;
    sp_overflow = 1'b0;
    sp_invalid  = 1'b0;
    case (fp_op_t'(bus.opcode))
      OP_CVT_S_W: begin
        if (bus.operand == 32'd0) special = 1'b1;
      end
      OP_TRUNC_W_S, OP_ROUND_W_S: begin
        if (in_e == 8'hFF) begin
          special    = 1'b1;
          sp_result  = INVALID_RESULT;
          sp_invalid = 1'b1;
        end else if (bus.operand == FP_NEG_2_31) begin
          special   = 1'b1;
          sp_result = 32'h80000000;
        end else if (in_e >= EXP_WORD_MAX) begin
          special     = 1'b1;
          sp_result   = INVALID_RESULT;
          sp_invalid  = 1'b1;
          sp_overflow = 1'b1;
        end else if (in_e == 8'd0) begin
          special    = 1'b1;
          sp_inexact = |in_m;
        end else if (in_e < 8'd126) begin
          special    = 1'b1;
          sp_inexact = 1'b1;
        end
      end
      default: begin
        special    = 1'b1;
        sp_invalid = 1'b1;
      end
    endcase
  end

  // Rounding inputs depend on direction: cvt rounds at bit 8 of the
  // normalised magnitude, float->int rounds at bit 0 of the aligned value.
  logic is_cvt;
  logic rnd_lsb;
  logic rnd_guard;
  logic rnd_sticky;
  logic rnd_mode;
  logic rnd_inc;

  assign is_cvt     = (op == OP_CVT_S_W);
  assign rnd_lsb    = is_cvt ? work[8] : work[0];
  assign rnd_guard  = is_cvt ? work[7] : guard_r;
  assign rnd_sticky = is_cvt ? |work[6:0] : sticky_r;
  assign rnd_mode   = (op != OP_TRUNC_W_S);

  fp_round_rne u_round (
    .lsb       (rnd_lsb),
    .guard     (rnd_guard),
    .sticky    (rnd_sticky),
    .mode      (rnd_mode),
    .increment (rnd_inc)
  );

  // Final values computed in ROUND.
  logic [23:0] mant_sum;
  logic [7:0]  cvt_exp;
  logic [31:0] cvt_result;
  logic [31:0] word_mag;
  logic        word_ovf;
  logic [31:0] final_result;

  // Assemble the rounded result for whichever direction is active.
  always_comb begin
    mant_sum     = {1'b0, work[30:8]} + {23'd0, rnd_inc};
    cvt_exp      = exp + {7'd0, mant_sum[23]};
    cvt_result   = {sign, cvt_exp, mant_sum[22:0]};
    word_mag     = work + {31'd0, rnd_inc};
    word_ovf     = word_mag[31] & ~sign;
    final_result = 32'd0;
    if (is_cvt)        final_result = cvt_result;
    else if (word_ovf) final_result = INVALID_RESULT;
    else if (sign)     final_result = ~word_mag + 32'd1;
    else               final_result = word_mag;
  end

  // Conversion FSM with registered result and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_CVT_S_W;
      sign       <= 1'b0;
      work       <= 32'd0;
      exp        <= 8'd0;
      cnt        <= 6'd0;
      guard_r    <= 1'b0;
      sticky_r   <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= 32'd0;
      zero_r     <= 1'b0;
      inexact_r  <= 1'b0;
      overflow_r <= 1'b0;
      invalid_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op         <= fp_op_t'(bus.opcode);
            sign       <= bus.operand[31];
            guard_r    <= 1'b0;
            sticky_r   <= 1'b0;
            result_r   <= 32'd0;
            zero_r     <= 1'b0;
            inexact_r  <= 1'b0;
            overflow_r <= 1'b0;
            invalid_r  <= 1'b0;
            if (special) begin
              result_r   <= sp_result;
              zero_r     <= (sp_result == 32'd0);
              inexact_r  <= sp_inexact;
              overflow_r <= sp_overflow;
              invalid_r  <= sp_invalid;
              done_r     <= 1'b1;
              state      <= DONE;
            end else if (fp_op_t'(bus.opcode) == OP_CVT_S_W) begin
              work  <= abs_in;
              exp   <= EXP_WORD_MAX;
              // Already normalised magnitudes skip straight to rounding.
              state <= abs_in[31] ? ROUND : SHIFT;
            end else begin
              work  <= {1'b1, in_m, 8'd0};
              cnt   <= 6'(EXP_WORD_MAX - in_e);
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (is_cvt) begin
            work <= work << 1;
            exp  <= exp - 8'd1;
            if (work[30]) state <= ROUND;
          end else begin
            work     <= work >> 1;
            guard_r  <= work[0];
            sticky_r <= sticky_r | guard_r;
            cnt      <= cnt - 6'd1;
            if (cnt == 6'd1) state <= ROUND;
          end
        end
        ROUND: begin
          result_r   <= final_result;
          zero_r     <= (final_result == 32'd0);
          inexact_r  <= rnd_guard | rnd_sticky;
          overflow_r <= ~is_cvt & word_ovf;
          invalid_r  <= ~is_cvt & word_ovf;
          done_r     <= 1'b1;
          state      <= DONE;
        end
        default: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.Inexact   = inexact_r;
  assign bus.Overflow  = overflow_r;
  assign bus.Invalid   = invalid_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_fp_convert_unit.sv
// Bench for fp_convert_unit: directed cases, randomized operands against a
// rational-arithmetic reference model, busy/reset behaviour.
module tb_fp_convert_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [35:0] exp_q[$];

  fp_convert_unit_if bus();

  fp_convert_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: value-level conversion with nearest-even rounding.
  // Vector layout {result, zero, Inexact, Overflow, Invalid}.
  task automatic model(input logic [1:0] op, input logic [31:0] a,
                       output logic [35:0] v, output int lat);
    logic [63:0] mag, q, rem, half, sig;
    logic [31:0] r;
    logic        inx, ovf, inv;
    int          p, sh, ee, e;
    r = 32'd0; inx = 0; ovf = 0; inv = 0; lat = 1;
    e = int'(a[30:23]);
    if (op == 2'b00) begin
      if (a != 32'd0) begin
        mag = {32'd0, a};
        if (a[31]) mag = 64'h1_0000_0000 - mag;
        p = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) p = i;
        lat = (31 - p) + 2;
        ee = 127 + p;
        if (p > 23) begin
          sh   = p - 23;
          q    = mag >> sh;
          rem  = mag - (q << sh);
          half = 64'd1 << (sh - 1);
          inx  = (rem != 0);
          if (rem > half || (rem == half && q[0])) q = q + 1;
          if (q == (64'd1 << 24)) begin q = q >> 1; ee = ee + 1; end
        end else begin
          q = mag << (23 - p);
        end
        r = {a[31], 8'(ee), q[22:0]};
      end
    end else if (op == 2'b11) begin
      inv = 1;
    end else begin
      if (e == 255) begin r = 32'h7FFFFFFF; inv = 1; end
      else if (a == 32'hCF000000) r = 32'h80000000;
      else if (e >= 158) begin r = 32'h7FFFFFFF; inv = 1; ovf = 1; end
      else if (e == 0) inx = |a[22:0];
      else if (e < 126) inx = 1;
      else begin
        lat = (158 - e) + 2;
        sig = {40'd0, 1'b1, a[22:0]};
        if (e >= 150) begin
          q = sig << (e - 150);
        end else begin
          sh   = 150 - e;
          q    = sig >> sh;
          rem  = sig - (q << sh);
          half = 64'd1 << (sh - 1);
          inx  = (rem != 0);
          if (op == 2'b10 && (rem > half || (rem == half && q[0]))) q = q + 1;
        end
        if (!a[31] && q == 64'h8000_0000) begin
          r = 32'h7FFFFFFF; inv = 1; ovf = 1;
        end else begin
          r = a[31] ? (32'd0 - q[31:0]) : q[31:0];
        end
      end
    end
    v = {r, (r == 32'd0), inx, ovf, inv};
  endtask

  // Driver: issue one request, wait (bounded) for done, then one more edge
  // to let the unit return to IDLE. idle_ok reports done low, busy low.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       output logic [35:0] got, output int lat,
                       output logic idle_ok);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operand = a;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus.result, bus.zero, bus.Inexact, bus.Overflow, bus.Invalid};
    @(posedge clk); #1;
    idle_ok = !bus.done && !bus.busy;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.busy, bus.done, bus.result, bus.zero, bus.Inexact, bus.Overflow};
    total++;
    if (obs !== 37'd0 || bus.Invalid !== 1'b0) begin
      $display("FAIL reset_outputs: got %h invalid=%b, want 0", obs, bus.Invalid);
      bad++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cvt();
    logic [31:0] t_a [6] = '{32'h00000001, 32'hFFFFFFFF, 32'h01000001,
                             32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    logic [35:0] t_v [6] = '{{32'h3F800000, 4'b0000}, {32'hBF800000, 4'b0000},
                             {32'h4B800000, 4'b0100}, {32'h4F000000, 4'b0100},
                             {32'hCF000000, 4'b0000}, {32'h00000000, 4'b1000}};
    int t_l [6] = '{33, 33, 9, 3, 2, 1};
    logic [35:0] got; int lat; logic idle_ok;
    for (int i = 0; i < 6; i++) begin
      do_op(2'b00, t_a[i], got, lat, idle_ok);
      total++;
      if (got !== t_v[i]) begin
        $display("FAIL cvt_value[%0d]: got %h want %h", i, got, t_v[i]); bad++;
      end
      total++;
      if (lat != t_l[i]) begin
        $display("FAIL cvt_latency[%0d]: got %0d want %0d", i, lat, t_l[i]); bad++;
      end
      total++;
      if (idle_ok !== 1'b1) begin
        $display("FAIL cvt_done_pulse[%0d]: got %b want 1", i, idle_ok); bad++;
      end
    end
  endtask

  task automatic test_word();
    logic [1:0]  t_o [10] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01,
                              2'b01, 2'b11, 2'b10, 2'b01, 2'b01};
    logic [31:0] t_a [10] = '{32'hC0300000, 32'hC0300000, 32'h40200000,
                              32'h7F800000, 32'h4F000000, 32'hCF000000,
                              32'h12345678, 32'h3F000000, 32'h3E800000,
                              32'h00000001};
    logic [35:0] t_v [10] = '{{32'hFFFFFFFE, 4'b0100}, {32'hFFFFFFFD, 4'b0100},
                              {32'h00000002, 4'b0100}, {32'h7FFFFFFF, 4'b0001},
                              {32'h7FFFFFFF, 4'b0011}, {32'h80000000, 4'b0000},
                              {32'h00000000, 4'b1001}, {32'h00000000, 4'b1100},
                              {32'h00000000, 4'b1100}, {32'h00000000, 4'b1100}};
    int t_l [10] = '{32, 32, 32, 1, 1, 1, 1, 34, 1, 1};
    logic [35:0] got; int lat; logic idle_ok;
    for (int i = 0; i < 10; i++) begin
      do_op(t_o[i], t_a[i], got, lat, idle_ok);
      total++;
      if (got !== t_v[i]) begin
        $display("FAIL word_value[%0d]: got %h want %h", i, got, t_v[i]); bad++;
      end
      total++;
      if (lat != t_l[i]) begin
        $display("FAIL word_latency[%0d]: got %0d want %0d", i, lat, t_l[i]); bad++;
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [35:0] v, got, want;
    int          lat, mlat, sel;
    logic        idle_ok;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        op = 2'b00;
        a  = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
      end else if (sel < 9) begin
        op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        a[31]    = 1'($urandom_range(0, 1));
        a[30:23] = 8'($urandom_range(120, 160));
        a[22:0]  = 23'($urandom);
        if ($urandom_range(0, 15) == 0) a[30:23] = 8'h00;
        if ($urandom_range(0, 15) == 0) a[30:23] = 8'hFF;
      end else begin
        op = 2'b11;
        a  = $urandom;
      end
      model(op, a, v, mlat);
      exp_q.push_back(v);
      do_op(op, a, got, lat, idle_ok);
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        $display("FAIL rand_value op=%0d a=%h: got %h want %h", op, a, got, want);
        bad++;
      end
      total++;
      if (lat != mlat) begin
        $display("FAIL rand_latency op=%0d a=%h: got %0d want %0d", op, a, lat, mlat);
        bad++;
      end
    end
  endtask

  // Results stay put while idle, and requests issued with no gap all complete.
  task automatic test_back_to_back();
    logic [31:0] t_a [4] = '{32'h00000003, 32'h41200000, 32'hFFFFFFF6, 32'h3FC00000};
    logic [1:0]  t_o [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
    logic [35:0] t_v [4] = '{{32'h40400000, 4'b0000}, {32'h0000000A, 4'b0000},
                             {32'hC1200000, 4'b0000}, {32'h00000002, 4'b0100}};
    logic [35:0] got, held; int lat; logic idle_ok;
    for (int i = 0; i < 4; i++) begin
      do_op(t_o[i], t_a[i], got, lat, idle_ok);
      total++;
      if (got !== t_v[i]) begin
        $display("FAIL b2b_value[%0d]: got %h want %h", i, got, t_v[i]); bad++;
      end
    end
    repeat (5) @(posedge clk);
    #1;
    held = {bus.result, bus.zero, bus.Inexact, bus.Overflow, bus.Invalid};
    total++;
    if (held !== t_v[3]) begin
      $display("FAIL b2b_hold: got %h want %h", held, t_v[3]); bad++;
    end
  endtask

  // A start while busy is dropped; reset mid-operation aborts silently.
  task automatic test_busy_reset();
    logic [35:0] got; int lat; logic idle_ok; int done_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 2'b00; bus.operand = 32'h00000001;
    @(posedge clk); #1;                       // edge 1
    bus.start = 1'b0;
    @(negedge clk);                           // before edge 2
    @(negedge clk);                           // before edge 3
    bus.start = 1'b1; bus.opcode = 2'b00; bus.operand = 32'h00000000;
    @(posedge clk); #1;                       // edge 3
    bus.start = 1'b0;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL busy_ignore: done=%b busy=%b, want done=0 busy=1", bus.done, bus.busy);
      bad++;
    end
    @(negedge clk);                           // before edge 4
    @(negedge clk);                           // before edge 5
    reset = 1'b1;
    @(posedge clk); #1;                       // edge 5
    total++;
    if ({bus.busy, bus.done, bus.result, bus.zero, bus.Inexact, bus.Overflow, bus.Invalid} !== 38'd0) begin
      $display("FAIL mid_reset: busy=%b done=%b result=%h, want all 0",
               bus.busy, bus.done, bus.result);
      bad++;
    end
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); bad++;
    end
    do_op(2'b00, 32'h00000001, got, lat, idle_ok);
    total++;
    if (got !== {32'h3F800000, 4'b0000} || lat != 33) begin
      $display("FAIL after_reset: got %h lat %0d want %h lat 33", got, lat, {32'h3F800000, 4'b0000});
      bad++;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = 2'b00; bus.operand = 32'd0;
    test_reset();
    test_cvt();
    test_word();
    test_random();
    test_back_to_back();
    test_busy_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_convert_unit.md
Name: fp_convert_unit

Overview:
- Multi-cycle IEEE-754 single/word converter for the MIPS FPU datapath.
- Encodes 32-bit two's-complement integers into single-precision bit patterns (cvt.s.w).
- Decodes single-precision patterns back into integers (trunc.w.s, round.w.s).
- Sits beside floating_point_alu, uses the same flag names, normalises one bit per cycle, start/done handshake.

Parameters:
- INVALID_RESULT, 32'h7FFFFFFF: integer result on NaN/Inf/out-of-range float->int.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- opcode  in  2  00 CVT_S_W, 01 TRUNC_W_S, 10 ROUND_W_S (nearest-even), 11 reserved
- operand  in  32  integer or float bits, captured with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result and flags valid
- result  out  32  converted value, held until next accepted start
- zero  out  1  result == 0
- Inexact  out  1  discarded bits nonzero
- Overflow  out  1  float magnitude too large for word
- Invalid  out  1  NaN/Inf/overflow/reserved opcode

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy, done, result, all flags = 0.
- Reset mid-operation aborts; no done pulse follows.
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE: start=1 captures opcode/operand and clears flags.
  - Special cases go IDLE->DONE: done visible after edge 1.
  - Otherwise IDLE->SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored and not queued.
- CVT_S_W:
  - sign = operand[31]; mag = |operand| as 32-bit unsigned (0x80000000 -> mag 2^31); exp = 158.
  - mag==0 is a special case: result 0x00000000, zero=1.
  - SHIFT: if mag[31]=0, mag <<= 1 and exp -= 1; else go to ROUND.
  - ROUND: mant = mag[30:8], guard = mag[7], sticky = |mag[6:0]; increment when guard & (sticky | mant[0]).
  - Mantissa carry-out sets mant = 0 and exp += 1.
  - Inexact = guard | sticky; result = {sign, exp[7:0], mant}.
  - Latency: done visible after edge k+2, k = leading zeros of mag (max 33 edges).
- TRUNC_W_S / ROUND_W_S, with e = operand[30:23]:
  - e==255: result INVALID_RESULT, Invalid=1.
  - Operand 0xCF000000 (-2^31): result 0x80000000, no flags.
  - Any other e>=158: result INVALID_RESULT, Invalid=1, Overflow=1.
  - e==0 (zero/denormal flushed): result 0; Inexact = |mantissa.
  - e<126: result 0; Inexact=1.
  - All of the above are special cases.
  - Otherwise sig = {1, mantissa, 8'b0} is shifted right (158-e) times in SHIFT, one per cycle.
    - guard = last bit shifted out; sticky ORs all earlier bits shifted out.
  - ROUND: TRUNC adds nothing; ROUND adds guard & (sticky | sig[0]).
  - Inexact = guard | sticky; result = sign ? -sig : sig.
  - Rounded positive magnitude 2^31 -> INVALID_RESULT, Invalid=1, Overflow=1.
  - Latency: done visible after edge (158-e)+2.
- opcode 11: special case; result 0, Invalid=1.
- zero is computed on the final result for every opcode.

Decomposition:
- Package fp_pkg:
  - fp_op_t (opcode encodings) and conv_state_t (IDLE/SHIFT/ROUND/DONE).
  - Constants EXP_BIAS=127, EXP_WORD_MAX=158, FP_NEG_2_31=32'hCF000000.
- One combinational sub-module, fp_round_rne (inputs lsb, guard, sticky, mode; outputs increment), shared by both conversion directions.

Test Plan:
- CVT_S_W 0x00000001 -> 0x3F800000, done after edge 33, flags 0; 0xFFFFFFFF -> 0xBF800000.
- CVT_S_W 0x01000001 -> 0x4B800000, Inexact=1 (tie to even); 0x7FFFFFFF -> 0x4F000000, Inexact=1 (carry into exponent).
- CVT_S_W 0x80000000 -> 0xCF000000, done after edge 2; 0x00000000 -> 0x00000000, zero=1, done after edge 1.
- TRUNC_W_S 0xC0300000 (-2.75) -> 0xFFFFFFFE, Inexact=1.
  - ROUND_W_S same operand -> 0xFFFFFFFD.
  - ROUND_W_S 0x40200000 (2.5) -> 0x00000002, Inexact=1.
- TRUNC_W_S 0x7F800000 -> 0x7FFFFFFF, Invalid=1.
  - 0x4F000000 -> 0x7FFFFFFF, Invalid=1, Overflow=1.
  - 0xCF000000 -> 0x80000000, no flags.
- start CVT_S_W 1; second start at edge 3 ignored; reset at edge 5 -> busy=0, outputs 0, no done.
  - Next start after reset completes normally.
